// File: rtl/rv_pkg.sv
// Shared RV64IM encodings and types for the execute stage and its muldiv engine.
package rv_pkg;

   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;
   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

   // Encoded so that funct3 of an M instruction casts straight to the op
   typedef enum logic [2:0] {
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } muldiv_op_e;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M engine: shift-add multiply and restoring divide on operand
// magnitudes, with sign correction applied when the result is presented.
module muldiv_unit
   import rv_pkg::*;
#(
   parameter int MUL_ITERS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hit,
   input  logic        start,
   input  muldiv_op_e  op,
   input  logic        is_w,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);

   localparam int CW = $clog2(MUL_ITERS + 1);

   md_state_e        state;
   logic [CW-1:0]    cnt;
   muldiv_op_e       op_q;
   logic             w_q, neg_a_q, neg_res_q, div_zero_q;
   logic [127:0]     acc, mcand;
   logic [63:0]      mplier, quo, divisor;
   logic [64:0]      rem;

   logic             a_signed, b_signed, neg_a, neg_b;
   logic [63:0]      op_a, op_b, mag_a, mag_b;
   logic [64:0]      rem_sh, rem_nxt;
   logic [63:0]      quo_nxt;
   logic [127:0]     prod;
   logic [63:0]      quot, remd, sel;

   // Operand preparation: W forms narrow to 32 bits, signed ops take magnitudes
   always_comb begin
      a_signed = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
      b_signed = (op == MULH) || (op == DIV) || (op == REM);
      op_a = is_w ? (a_signed ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
      op_b = is_w ? (b_signed ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
      neg_a = a_signed && op_a[63];
      neg_b = b_signed && op_b[63];
      mag_a = neg_a ? -op_a : op_a;
      mag_b = neg_b ? -op_b : op_b;
   end

   // One restoring-divide step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      rem_sh = {rem[63:0], quo[63]};
      if (rem_sh >= {1'b0, divisor}) begin
         rem_nxt = rem_sh - {1'b0, divisor};
         quo_nxt = {quo[62:0], 1'b1};
      end else begin
         rem_nxt = rem_sh;
         quo_nxt = {quo[62:0], 1'b0};
      end
   end

   // Control FSM and iterative datapath; everything freezes while hit is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= MUL;
         w_q        <= 1'b0;
         neg_a_q    <= 1'b0;
         neg_res_q  <= 1'b0;
         div_zero_q <= 1'b0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         rem        <= '0;
         quo        <= '0;
         divisor    <= '0;
      end else if (hit) begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q       <= op;
                  w_q        <= is_w;
                  neg_a_q    <= neg_a;
                  neg_res_q  <= neg_a ^ neg_b;
                  div_zero_q <= (mag_b == 64'd0);
                  acc        <= '0;
                  mcand      <= {64'b0, mag_a};
                  mplier     <= mag_b;
                  rem        <= '0;
                  quo        <= is_w ? {mag_a[31:0], 32'b0} : mag_a;
                  divisor    <= mag_b;
                  cnt        <= is_w ? CW'(32) : CW'(MUL_ITERS);
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= {mcand[126:0], 1'b0};
               mplier <= {1'b0, mplier[63:1]};
               rem    <= rem_nxt;
               quo    <= quo_nxt;
               cnt    <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Sign correction and result selection; a zero divisor forces an all-ones quotient
   always_comb begin
      prod = neg_res_q ? -acc : acc;
      quot = div_zero_q ? '1 : (neg_res_q ? -quo : quo);
      remd = neg_a_q ? -rem[63:0] : rem[63:0];
      case (op_q)
         MUL:                 sel = prod[63:0];
         MULH, MULHSU, MULHU: sel = prod[127:64];
         DIV, DIVU:           sel = quot;
         default:             sel = remd;
      endcase
      result = w_q ? sext32(sel[31:0]) : sel;
      busy   = (state == BUSY) || ((state == IDLE) && start);
      done   = (state == DONE);
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle RV64I ALU and branch resolution, with M ops
// handed to the iterative muldiv engine while the pipeline is frozen.
module ex_stage
   import rv_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int MUL_ITERS = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            hit,
   input  logic            noop,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] valA,
   input  logic [XLEN-1:0] valB,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pcplus4,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target,
   output logic            busy
);

   logic        is_m, md_start, md_busy, md_done;
   logic [63:0] md_result, op_b, alu;
   logic [31:0] w32;
   logic        br_cond;
   logic [63:0] br_target;

   assign is_m     = ((opcode == OP) || (opcode == OP_32)) && (funct7 == MULDIV_FUNCT7);
   assign md_start = is_m && !noop && hit;

   muldiv_unit #(.MUL_ITERS(MUL_ITERS)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .hit    (hit),
      .start  (md_start),
      .op     (muldiv_op_e'(funct3)),
      .is_w   (opcode == OP_32),
      .a      (valA),
      .b      (valB),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // Integer ALU; immediate forms substitute imm for rs2, W forms sign-extend bit 31
   always_comb begin
      op_b = ((opcode == OP) || (opcode == OP_32)) ? valB : imm;
      alu  = '0;
      w32  = '0;
      case (opcode)
         OP, OP_IMM: begin
            case (funct3)
               F3_ADD:  alu = ((opcode == OP) && funct7[5]) ? valA - op_b : valA + op_b;
               F3_SLL:  alu = valA << op_b[5:0];
               F3_SLT:  alu = {63'b0, $signed(valA) < $signed(op_b)};
               F3_SLTU: alu = {63'b0, valA < op_b};
               F3_XOR:  alu = valA ^ op_b;
               F3_SRL:  alu = funct7[5] ? $unsigned($signed(valA) >>> op_b[5:0]) : valA >> op_b[5:0];
               F3_OR:   alu = valA | op_b;
               default: alu = valA & op_b;
            endcase
         end
         OP_32, OP_IMM_32: begin
            case (funct3)
               F3_ADD:  w32 = ((opcode == OP_32) && funct7[5]) ? valA[31:0] - op_b[31:0]
                                                                : valA[31:0] + op_b[31:0];
               F3_SLL:  w32 = valA[31:0] << op_b[4:0];
               F3_SRL:  w32 = funct7[5] ? $unsigned($signed(valA[31:0]) >>> op_b[4:0])
                                        : valA[31:0] >> op_b[4:0];
               default: w32 = '0;
            endcase
            alu = sext32(w32);
         end
         LUI:         alu = imm;
         AUIPC:       alu = pc + imm;
         LOAD, STORE: alu = valA + imm;
         JAL, JALR:   alu = pcplus4;
         default:     alu = '0;
      endcase
   end

   // Branch unit: conditional compares plus unconditional jumps
   always_comb begin
      br_cond   = 1'b0;
      br_target = pc + imm;
      case (opcode)
         BRANCH: begin
            case (funct3)
               F3_BEQ:  br_cond = (valA == valB);
               F3_BNE:  br_cond = (valA != valB);
               F3_BLT:  br_cond = ($signed(valA) < $signed(valB));
               F3_BGE:  br_cond = ($signed(valA) >= $signed(valB));
               F3_BLTU: br_cond = (valA < valB);
               F3_BGEU: br_cond = (valA >= valB);
               default: br_cond = 1'b0;
            endcase
         end
         JAL:  br_cond = 1'b1;
         JALR: begin
            br_cond   = 1'b1;
            br_target = (valA + imm) & ~64'd1;
         end
         default: br_cond = 1'b0;
      endcase
   end

   // Output mux: a finished M op owns the outputs; otherwise the single-cycle path reports
   always_comb begin
      result        = alu;
      result_valid  = 1'b0;
      branch_taken  = 1'b0;
      branch_target = br_target;
      busy          = md_busy && !reset;
      if (md_done) begin
         result       = md_result;
         result_valid = 1'b1;
      end else if (!md_busy && !reset) begin
         result_valid = !noop && !is_m;
         branch_taken = br_cond && !noop;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU, branches, iterative muldiv, stalls and reset.
module tb_ex_stage;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, hit, noop;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [63:0] valA, valB, imm, pc, pcplus4;
   logic [63:0] result, branch_target;
   logic        result_valid, branch_taken, busy;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] a, b, im, p, exp;
   } alu_vec_t;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [63:0] a, b, im, p;
      logic        nop, taken;
      logic [63:0] target;
   } br_vec_t;

   ex_stage #(.XLEN(64), .MUL_ITERS(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .hit           (hit),
      .noop          (noop),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7        (funct7),
      .valA          (valA),
      .valB          (valB),
      .imm           (imm),
      .pc            (pc),
      .pcplus4       (pcplus4),
      .result        (result),
      .result_valid  (result_valid),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .busy          (busy)
   );

   // Free-running pipeline clock
   always #5 clk = ~clk;

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                        input logic [63:0] p);
      opcode = opc; funct3 = f3; funct7 = f7;
      valA = a; valB = b; imm = im; pc = p; pcplus4 = p + 64'd4;
      noop = 1'b0; hit = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(JAL, 3'd0, 7'd0, 64'd0, 64'd0, 64'h40, 64'h200);
      #2;
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", result_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
      checks++;
      if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken got %b expected 0", branch_taken); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      noop  = 1'b1;
      #1;
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL noop_valid got %b expected 0", result_valid); end
   endtask

   task automatic test_alu();
      alu_vec_t v[$];
      logic [63:0] want;
      v.push_back('{OP_IMM,    F3_ADD,  7'h00, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE});
      v.push_back('{OP,        F3_ADD,  7'h20, 64'd10, 64'd3, 64'd0, 64'd0, 64'd7});
      v.push_back('{OP,        F3_SLT,  7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd1});
      v.push_back('{OP,        F3_SLTU, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0});
      v.push_back('{OP_IMM,    F3_SRL,  7'h20, 64'h8000_0000_0000_0000, 64'd0, 64'h404, 64'd0, 64'hF800_0000_0000_0000});
      v.push_back('{OP_32,     F3_ADD,  7'h00, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'd0, 64'hFFFF_FFFF_8000_0000});
      v.push_back('{OP_IMM_32, F3_SLL,  7'h00, 64'h4000_0000, 64'd0, 64'd33, 64'd0, 64'hFFFF_FFFF_8000_0000});
      v.push_back('{LUI,       3'd0,    7'h00, 64'd0, 64'd0, 64'h1234_5000, 64'd0, 64'h1234_5000});
      v.push_back('{AUIPC,     3'd0,    7'h00, 64'd0, 64'd0, 64'h20, 64'h1000, 64'h1020});
      v.push_back('{LOAD,      3'd3,    7'h00, 64'h2000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'h1FF0});
      v.push_back('{JAL,       3'd0,    7'h00, 64'd0, 64'd0, 64'h80, 64'h300, 64'h304});
      foreach (v[i]) begin
         @(negedge clk);
         drive(v[i].opc, v[i].f3, v[i].f7, v[i].a, v[i].b, v[i].im, v[i].p);
         exp_q.push_back(v[i].exp);
         #1;
         checks++;
         if (result_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_valid[%0d] got valid=%b busy=%b expected valid=1 busy=0", i, result_valid, busy);
         end
         if (result_valid === 1'b1) begin
            want = exp_q.pop_front();
            checks++;
            if (result !== want) begin
               errors++;
               $display("[TB] FAIL alu_result[%0d] got %h expected %h", i, result, want);
            end
         end else begin
            exp_q.delete();
         end
      end
   endtask

   task automatic test_branch();
      br_vec_t v[$];
      v.push_back('{BRANCH, F3_BLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 64'h100, 1'b0, 1'b1, 64'h120});
      v.push_back('{BRANCH, F3_BLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 64'h100, 1'b1, 1'b0, 64'h120});
      v.push_back('{BRANCH, F3_BGE,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 64'h100, 1'b0, 1'b0, 64'h120});
      v.push_back('{BRANCH, F3_BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 64'h100, 1'b0, 1'b0, 64'h120});
      v.push_back('{BRANCH, F3_BGEU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 64'h100, 1'b0, 1'b1, 64'h120});
      v.push_back('{BRANCH, F3_BEQ,  64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h200, 1'b0, 1'b1, 64'h1F8});
      v.push_back('{BRANCH, F3_BNE,  64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h200, 1'b0, 1'b0, 64'h1F8});
      v.push_back('{JALR,   3'd0,    64'h1001, 64'd0, 64'h10, 64'h400, 1'b0, 1'b1, 64'h1010});
      v.push_back('{JAL,    3'd0,    64'd0, 64'd0, 64'h80, 64'h400, 1'b0, 1'b1, 64'h480});
      foreach (v[i]) begin
         @(negedge clk);
         drive(v[i].opc, v[i].f3, 7'd0, v[i].a, v[i].b, v[i].im, v[i].p);
         noop = v[i].nop;
         #1;
         checks++;
         if (branch_taken !== v[i].taken) begin
            errors++;
            $display("[TB] FAIL br_taken[%0d] got %b expected %b", i, branch_taken, v[i].taken);
         end
         if (v[i].taken) begin
            checks++;
            if (branch_target !== v[i].target) begin
               errors++;
               $display("[TB] FAIL br_target[%0d] got %h expected %h", i, branch_target, v[i].target);
            end
         end
      end
   endtask

   task automatic run_md(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] want_res, input int exp_lat,
                         input int stall_at, input int stall_len);
      int lat;
      logic [63:0] want;
      @(negedge clk);
      drive(opc, f3, MULDIV_FUNCT7, a, b, 64'd0, 64'h800);
      exp_q.push_back(want_res);
      #1;
      checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL md_accept got busy=%b valid=%b expected busy=1 valid=0", busy, result_valid);
      end
      @(negedge clk);
      noop = 1'b1;
      lat  = 1;
      while (result_valid !== 1'b1 && lat < 300) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL md_busy cycle %0d got %b expected 1", lat, busy);
         end
         hit = (stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len) ? 1'b0 : 1'b1;
         @(negedge clk);
         lat++;
      end
      hit = 1'b1;
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("[TB] FAIL md_latency got %0d expected %0d", lat, exp_lat);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL md_done_busy got %b expected 0", busy);
      end
      if (result_valid === 1'b1) begin
         want = exp_q.pop_front();
         checks++;
         if (result !== want) begin
            errors++;
            $display("[TB] FAIL md_result op=%0d f3=%0d got %h expected %h", opc, f3, result, want);
         end
      end else begin
         exp_q.delete();
      end
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL md_pulse got %b expected 0", result_valid);
      end
   endtask

   task automatic test_muldiv();
      run_md(OP,    3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 0, 0);
      run_md(OP,    3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0, 0);
      run_md(OP,    3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, 0);
      run_md(OP,    3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65, 0, 0);
      run_md(OP,    3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 0, 0);
      run_md(OP,    3'd5, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, 0);
      run_md(OP,    3'd7, 64'd7, 64'd0, 64'd7, 65, 0, 0);
      run_md(OP,    3'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65, 0, 0);
      run_md(OP_32, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 0);
      run_md(OP_32, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0, 0);
   endtask

   task automatic test_stall();
      run_md(OP_32, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 43, 5, 10);
   endtask

   task automatic test_reset_mid();
      logic [63:0] want;
      @(negedge clk);
      drive(OP, 3'd4, MULDIV_FUNCT7, 64'd100, 64'd7, 64'd0, 64'h0);
      @(negedge clk);
      noop = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre_busy got %b expected 1", busy); end
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b expected 0", busy); end
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b expected 0", result_valid); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      drive(OP, F3_ADD, 7'h00, 64'd2, 64'd3, 64'd0, 64'd0);
      exp_q.push_back(64'd5);
      #1;
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_rst_valid got valid=%b busy=%b expected valid=1 busy=0", result_valid, busy);
      end
      if (result_valid === 1'b1) begin
         want = exp_q.pop_front();
         checks++;
         if (result !== want) begin errors++; $display("[TB] FAIL post_rst_result got %h expected %h", result, want); end
      end else begin
         exp_q.delete();
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_muldiv();
      test_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its decoded fields and produces the ALU result and branch resolution for the EX/MEM register.
- Base RV64I integer/branch ops resolve combinationally in one cycle.
- RV64M multiply/divide run on an iterative shift-add / restoring-divide engine; `busy` freezes the pipeline until the result is ready.

Parameters:
- XLEN, 64, datapath width.
- MUL_ITERS, 64, iterations for 64-bit multiply and divide; W-forms use 32.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- hit  in  1  global advance enable (cache hit); when 0, all state holds.
- noop  in  1  bubble marker from ID/EX; when 1, no op starts and outputs report no result.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- valA  in  64  rs1 value.
- valB  in  64  rs2 value.
- imm  in  64  sign-extended immediate.
- pc  in  64  instruction PC.
- pcplus4  in  64  PC+4.
- result  out  64  ALU / muldiv / link result.
- result_valid  out  1  `result` is valid this cycle.
- branch_taken  out  1  redirect required.
- branch_target  out  64  redirect PC.
- busy  out  1  muldiv in progress; upstream holds ID/EX and EX/MEM inserts a bubble.

Behaviour:
- Reset (async): FSM=IDLE; iteration counter 0; accumulators 0; result_valid=0; busy=0; branch_taken=0.
- Base ops (OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC, loads/stores address calc):
  - result is combinational from the inputs; result_valid=!noop, in the same cycle.
  - *W forms compute on [31:0] and sign-extend bit 31.
  - Shift amounts: [5:0] for 64-bit forms, [4:0] for W forms.
- Branches:
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: branch_taken per comparison of valA and valB; branch_target=pc+imm.
  - JAL: branch_taken=1; branch_target=pc+imm; result=pcplus4.
  - JALR: branch_taken=1; branch_target=(valA+imm)&~1; result=pcplus4.
  - noop=1 forces branch_taken=0.
- M ops are decoded as opcode OP or OP-32 with funct7=0000001.
- FSM IDLE:
  - On an M op with noop=0 and hit=1: latch operand magnitudes, sign flags, op, and W flag.
  - busy=1 from this cycle onward; counter = MUL_ITERS, or 32 for W forms; go to BUSY.
- FSM BUSY:
  - One iteration per cycle when hit=1.
  - MUL*: 128-bit shift-add; MULH/MULHSU/MULHU select [127:64].
  - DIV/REM*: restoring, one quotient bit per cycle.
  - Counter decrements each iteration; at 0, go to DONE.
- FSM DONE:
  - Apply sign correction; result=selected value; result_valid=1; busy=0 for exactly one cycle.
  - Return to IDLE.
  - Total latency for a 64-bit op: accept at cycle 0, result at cycle N+1 (65).
- While hit=0 (any state): the FSM, counter, and datapath hold; outputs hold.
- Divide by zero: quotient=all ones; remainder=dividend. No trap.
- Signed overflow (DIV, most-negative / -1): quotient=dividend; remainder=0. The W forms apply the same rules on 32-bit values.
- Inputs are ignored while in BUSY or DONE (the pipeline is frozen).
- Reset mid-operation: the operation is discarded immediately and busy drops asynchronously.
- result_valid is 0 in IDLE whenever noop=1, and 0 throughout BUSY.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP, OP_IMM, OP_32, OP_IMM_32, BRANCH, JAL, JALR, LUI, AUIPC, LOAD, STORE).
  - funct3 encodings.
  - MULDIV_FUNCT7.
  - Typedef muldiv_op_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - Typedef md_state_e (IDLE, BUSY, DONE).
- One sub-module, muldiv_unit: the FSM, counter, and iterative datapath. Interface:
  - Inputs: start, op, is_w, a, b.
  - Outputs: busy, done, result.
- ex_stage holds the combinational ALU, branch unit, and result mux.

Test Plan:
- ADDI, valA=5, imm=-7 -> result=0xFFFF_FFFF_FFFF_FFFE, result_valid=1 the same cycle, busy=0.
- BLT, valA=-1, valB=1, pc=0x100, imm=0x20 -> branch_taken=1, branch_target=0x120. The same stimulus with noop=1 -> branch_taken=0.
- MUL, valA=0xFFFF_FFFF_FFFF_FFFF, valB=2, using MULHU -> busy high for 65 cycles, then result=1 with one result_valid pulse. With MUL -> result=0xFFFF_FFFF_FFFF_FFFE.
- DIV, valA=0x8000_0000_0000_0000, valB=-1 -> result=0x8000_0000_0000_0000. REM with the same operands -> 0. DIVU x/0 -> all ones. REMU 7/0 -> 7.
- DIVW, valA=-7, valB=2 -> result=-3 after 33 cycles. hit=0 for 10 cycles mid-op -> result arrives 10 cycles later with an identical value.
- Assert reset during BUSY of a DIV -> busy=0 and result_valid=0 immediately. The next ADD after reset completes normally.
